multiplicador_uc: RTL and testbench
===================================

MULTIPLICADOR_UC -- requirements
Module: multiplicador_uc

Interface
REQ-001 SHALL have parameter CYC_W, default 8: width of the operation cycle counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1: request a multiplication; sampled only in IDLE.
REQ-005 SHALL have port qlsb, input, 1: LSB of datapath Q register.
REQ-006 SHALL have port zero, input, 1: datapath iteration counter equals 0.
REQ-007 SHALL have ports a_rst, a_en, b_en, q_en, cnt_en, a_ld, b_ld, q_ld, cnt_ld, output, 1 each: datapath controls.
- Register action: en=1,ld=1 loads; en=1,ld=0 shifts right; en=0 holds.
- Counter action: cnt_en=1,cnt_ld=1 loads WIDTH-1; cnt_en=1,cnt_ld=0 decrements.
REQ-008 SHALL have port ready, output, 1: high in IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse, product valid on datapath P_out.
REQ-010 SHALL have port cycles, output, CYC_W: cycle count of the last completed operation.

Function
REQ-011 SHALL implement a Moore FSM with states IDLE, INIT, TEST, ADD, SHIFT, DONE; all control outputs decoded from state only, except where REQ-016 uses zero.
REQ-012 IDLE: all controls 0, ready=1; start=1 -> INIT, else stay.
REQ-013 INIT: a_rst=1 (A cleared), b_en=b_ld=1, q_en=q_ld=1, cnt_en=cnt_ld=1; -> TEST unconditionally.
REQ-014 TEST: all controls 0; qlsb=1 -> ADD, qlsb=0 -> SHIFT.
REQ-015 ADD: a_en=a_ld=1 (A <= A+B); -> SHIFT.
REQ-016 SHIFT: a_en=q_en=1, a_ld=q_ld=0; cnt_en=1 only when zero=0; zero=1 -> DONE, zero=0 -> TEST.
REQ-017 DONE: done=1, all datapath controls 0; -> IDLE unconditionally, even if start=1.
REQ-018 Total: WIDTH SHIFT visits per operation; ADD visited exactly popcount(Q) times.
REQ-019 Latency: start sampled at edge k -> DONE entered at edge k+1+2*WIDTH+popcount(Q).
REQ-020 start asserted outside IDLE SHALL be ignored, not queued.
REQ-021 Internal counter SHALL clear on INIT entry, increment each cycle in INIT..SHIFT, and saturate at all-ones.
REQ-022 cycles SHALL update with the counter value on DONE entry and hold until the next DONE.
REQ-023 b_en, q_ld, b_ld and cnt_ld SHALL never be asserted outside INIT.
REQ-024 a_ld SHALL never be asserted together with q_en.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE from any state, including mid-operation.
REQ-026 After reset: ready=1, done=0, all datapath controls 0, cycles=0.
REQ-027 No partial operation SHALL resume after reset.
REQ-028 done SHALL NOT pulse for an aborted operation.

Verification (datapath WIDTH=4 attached)
REQ-029 B=3, Q=5, start one cycle -> done 11 cycles after start edge, P_out=15, cycles=10.
REQ-030 B=7, Q=0 -> no ADD state visited, done after 9 cycles, P_out=0.
REQ-031 B=15, Q=15 -> four ADD visits, done after 13 cycles, P_out=225 under datapath carry rules; test with B=5, Q=15 -> P_out=75.
REQ-032 start held high continuously -> back-to-back operations with one IDLE cycle between DONE and next INIT; ready=1 only in that cycle.
REQ-033 rst pulsed while in SHIFT of bit 2 -> next cycle IDLE, ready=1, no done pulse; new start B=2, Q=3 -> P_out=6.
REQ-034 start toggled during TEST/ADD/SHIFT -> ignored; exactly one done pulse per accepted start.

Source files
------------

// File: rtl/multiplicador_uc.sv
// Purpose : control unit for a shift-and-add multiplier; drives datapath load/shift/count enables.
// Latency : start sampled in IDLE -> done pulse 1 + 2*WIDTH + popcount(Q) cycles later.
// Backpressure: none; start is accepted only while ready=1, ignored (not queued) otherwise.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   start              - multiplication request (looked at only in IDLE)
//   qlsb, zero         - datapath status: Q[0], iteration counter == 0
//   a_rst .. cnt_ld    - datapath controls (en+ld = load, en alone = shift/decrement)
//   ready, done        - idle indicator, one-cycle product-valid pulse
//   cycles             - cycle count of the last completed operation
module multiplicador_uc #(
    parameter int CYC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             qlsb,
    input  logic             zero,
    output logic             a_rst,
    output logic             a_en,
    output logic             b_en,
    output logic             q_en,
    output logic             cnt_en,
    output logic             a_ld,
    output logic             b_ld,
    output logic             q_ld,
    output logic             cnt_ld,
    output logic             ready,
    output logic             done,
    output logic [CYC_W-1:0] cycles
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [CYC_W-1:0] CNT_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [CYC_W-1:0] r_cnt;
    logic [CYC_W-1:0] r_cycles;
    logic             w_busy;

    // Cycles spent in the working states are what the operation counter measures.
    assign w_busy = (r_state == S_INIT) || (r_state == S_TEST) ||
                    (r_state == S_ADD)  || (r_state == S_SHIFT);
    assign cycles = r_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_cycles <= '0;
        end else begin
            r_state <= w_next;

            if (r_state == S_IDLE && w_next == S_INIT) begin
                r_cnt <= '0;
            end else if (w_busy && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_ONE;
            end

            // Capture the pre-increment count on DONE entry: INIT..last SHIFT
            // minus the final SHIFT cycle, i.e. 2*WIDTH + popcount(Q).
            if (r_state == S_SHIFT && w_next == S_DONE) begin
                r_cycles <= r_cnt;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        a_rst  = 1'b0;
        a_en   = 1'b0;
        b_en   = 1'b0;
        q_en   = 1'b0;
        cnt_en = 1'b0;
        a_ld   = 1'b0;
        b_ld   = 1'b0;
        q_ld   = 1'b0;
        cnt_ld = 1'b0;
        ready  = 1'b0;
        done   = 1'b0;

        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_next = S_INIT;
                end
            end
            S_INIT: begin
                a_rst  = 1'b1;
                b_en   = 1'b1;
                b_ld   = 1'b1;
                q_en   = 1'b1;
                q_ld   = 1'b1;
                cnt_en = 1'b1;
                cnt_ld = 1'b1;
                w_next = S_TEST;
            end
            S_TEST: begin
                w_next = qlsb ? S_ADD : S_SHIFT;
            end
            S_ADD: begin
                a_en   = 1'b1;
                a_ld   = 1'b1;
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                // Last shift happens with the counter already at zero; don't wrap it.
                a_en   = 1'b1;
                q_en   = 1'b1;
                cnt_en = ~zero;
                w_next = zero ? S_DONE : S_TEST;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multiplicador_uc.sv
// Purpose : directed self-checking bench for multiplicador_uc with a 4-bit shift-add datapath.
// Latency : products and latencies compared against hand-computed constants.
// Backpressure: n/a; start is driven directly by the bench.
module tb_multiplicador_uc;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       qlsb;
    logic       zero;
    logic       a_rst, a_en, b_en, q_en, cnt_en, a_ld, b_ld, q_ld, cnt_ld;
    logic       ready, done;
    logic [7:0] cycles;

    // Datapath (WIDTH = 4): carry C, accumulator A, multiplicand B, multiplier Q.
    logic [3:0] in_b, in_q;
    logic [3:0] dp_a, dp_b, dp_q;
    logic       dp_c;
    logic [1:0] dp_cnt;
    logic [4:0] dp_sum;
    logic [7:0] p_out;

    int n_chk = 0;
    int n_err = 0;
    int viol  = 0;

    multiplicador_uc #(.CYC_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .qlsb   (qlsb),
        .zero   (zero),
        .a_rst  (a_rst),
        .a_en   (a_en),
        .b_en   (b_en),
        .q_en   (q_en),
        .cnt_en (cnt_en),
        .a_ld   (a_ld),
        .b_ld   (b_ld),
        .q_ld   (q_ld),
        .cnt_ld (cnt_ld),
        .ready  (ready),
        .done   (done),
        .cycles (cycles)
    );

    always #5 clk = ~clk;

    assign qlsb   = dp_q[0];
    assign zero   = (dp_cnt == 2'd0);
    assign dp_sum = {1'b0, dp_a} + {1'b0, dp_b};
    assign p_out  = {dp_a, dp_q};

    initial begin
        dp_a   = '0;
        dp_b   = '0;
        dp_q   = '0;
        dp_c   = 1'b0;
        dp_cnt = '0;
    end

    always @(posedge clk) begin
        if (a_rst) begin
            dp_a <= '0;
            dp_c <= 1'b0;
        end else if (a_en && a_ld) begin
            dp_c <= dp_sum[4];
            dp_a <= dp_sum[3:0];
        end else if (a_en) begin
            dp_a <= {dp_c, dp_a[3:1]};
            dp_c <= 1'b0;
        end
        if (b_en) dp_b <= b_ld ? in_b : {1'b0, dp_b[3:1]};
        if (q_en) dp_q <= q_ld ? in_q : {dp_a[0], dp_q[3:1]};
        if (cnt_en) dp_cnt <= cnt_ld ? 2'd3 : dp_cnt - 2'd1;
    end

    // Structural invariants: INIT-only controls, and no load of A while Q shifts.
    always @(negedge clk) begin
        if (!rst) begin
            if ((b_en || q_ld || b_ld || cnt_ld) && !a_rst) viol++;
            if (a_ld && q_en) viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] ctl();
        return {a_rst, a_en, b_en, q_en, cnt_en, a_ld, b_ld, q_ld, cnt_ld};
    endfunction

    // One operation from IDLE with a single-cycle start; checks latency, product, counts.
    task automatic run_op(input string tag, input logic [3:0] b, input logic [3:0] q,
                          input int exp_p, input int exp_lat, input int exp_cyc, input int exp_adds);
        int n;
        int adds;
        int shifts;
        in_b  = b;
        in_q  = q;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_init_ctl"}, 32'(ctl()), 32'h177);
        n = 0; adds = 0; shifts = 0;
        while (!done && n < 100) begin
            tick();
            n++;
            if (a_en && a_ld) adds++;
            if (a_en && q_en) shifts++;
        end
        chk({tag, "_lat"},    n,      exp_lat);
        chk({tag, "_p"},      p_out,  exp_p);
        chk({tag, "_cycles"}, cycles, exp_cyc);
        chk({tag, "_adds"},   adds,   exp_adds);
        chk({tag, "_shifts"}, shifts, 4);
        tick();
        chk({tag, "_idle"}, {ready, done}, 2'b10);
    endtask

    initial begin
        int n;
        int dones;
        int shifts;
        rst   = 1'b1;
        start = 1'b0;
        in_b  = '0;
        in_q  = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready",  ready,        1);
        chk("rst_done",   done,         0);
        chk("rst_ctl",    32'(ctl()),   0);
        chk("rst_cycles", cycles,       0);

        run_op("b3q5",   4'd3,  4'd5,  15,  11, 10, 2);
        run_op("b7q0",   4'd7,  4'd0,  0,   9,  8,  0);
        run_op("b15q15", 4'd15, 4'd15, 225, 13, 12, 4);
        run_op("b5q15",  4'd5,  4'd15, 75,  13, 12, 4);

        // start held high: DONE -> one IDLE cycle -> INIT again.
        in_b  = 4'd3;
        in_q  = 4'd5;
        start = 1'b1;
        tick();
        n = 0;
        while (!done && n < 100) begin tick(); n++; end
        chk("b2b_lat1", n, 11);
        chk("b2b_p1", p_out, 15);
        tick();
        chk("b2b_gap_ready", ready, 1);
        tick();
        chk("b2b_init_ready", ready, 0);
        chk("b2b_init_ctl", 32'(ctl()), 32'h177);
        n = 0;
        while (!done && n < 100) begin tick(); n++; end
        chk("b2b_lat2", n, 11);
        chk("b2b_p2", p_out, 15);
        start = 1'b0;
        tick();
        chk("b2b_end_ready", ready, 1);

        // Abort by reset during the SHIFT of bit 2.
        in_b  = 4'd6;
        in_q  = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        shifts = 0;
        n = 0;
        while (shifts < 3 && n < 100) begin
            tick();
            n++;
            if (a_en && q_en) shifts++;
        end
        chk("abort_reached", shifts, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready",  ready,      1);
        chk("abort_done",   done,       0);
        chk("abort_ctl",    32'(ctl()), 0);
        chk("abort_cycles", cycles,     0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);
        run_op("b2q3", 4'd2, 4'd3, 6, 11, 10, 2);

        // start toggling while busy is ignored.
        in_b  = 4'd3;
        in_q  = 4'd5;
        start = 1'b1;
        tick();
        n = 0;
        dones = 0;
        while (!done && n < 100) begin
            start = ~start;
            tick();
            n++;
        end
        start = 1'b0;
        if (done) dones++;
        chk("tog_lat", n, 11);
        chk("tog_p", p_out, 15);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dones++;
        end
        chk("tog_one_done", dones, 1);
        chk("tog_ready", ready, 1);

        chk("invariants", viol, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
